mcu_para_enquire_master: RTL
============================

Name: mcu_para_enquire_master

Overview:
- Initiator end of the FPGA↔MCU parameter-enquire exchange.
- On a request pulse it does three things:
  - sends a query frame through the byte-level UART interface (tx_data / start_tx / tx_idle);
  - receives the 16-byte parameter reply (rx_data / rx_ok);
  - validates the reply, then latches the six acquisition parameters atomically.
- It is used on the host/MCU-emulation side and in loopback self-test against the FPGA responder.

Parameters:
- CTRL_ENQUIRE, 8'h21, control code of the query and of the expected reply.
- PAYLOAD_LEN, 8'd16, expected reply LEN byte.
- TIMEOUT_CYCLES, 100_000_000, maximum clk cycles allowed from query-sent to checksum byte. This is 1 s at 100 MHz.
- TO_W, 27, timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-low. Clock port clk and reset port rst, named as in the codebase.
- req  in  1  one-cycle enquire request.
- tx_idle  in  1  UART transmitter idle (1 = idle).
- tx_data  out  8  byte to transmit.
- start_tx  out  1  one-cycle transmit strobe.
- rx_data  in  8  received byte.
- rx_ok  in  1  one-cycle rx_data valid.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle: valid reply latched.
- err  out  1  one-cycle: transaction failed.
- err_code  out  2  1 = ctrl/len mismatch, 2 = checksum, 3 = timeout. Held until the next req.
- travelling_wave_collect_freq  out  32
- travelling_wave_collect_duration  out  16
- travelling_wave_alarm_threshold  out  16
- power_frequency_collect_freq  out  32
- power_frequency_collect_duration  out  16
- power_frequency_alarm_threshold  out  16
- para_valid  out  1  set after the first valid reply; cleared only by reset.

Behaviour:
- Reset (rst == 0 at a clk edge): everything returns to power-on state.
  - All outputs are 0.
  - FSM goes to IDLE.
  - Parameter registers are 0 and para_valid is 0.
- Query frame: AA 55 CTRL_ENQUIRE 00 CHK, where CHK = CTRL_ENQUIRE + 00 (mod 256).
- Reply frame: AA 55 CTRL LEN P0..P15 CHK.
  - Payload is big-endian, in this order: tw_freq[31:0], tw_dur, tw_thr, pf_freq, pf_dur, pf_thr.
  - CHK = sum(CTRL, LEN, P0..P15) mod 256.
- TX handshake, per byte:
  - In TX_LOAD, when tx_idle == 1: drive tx_data and pulse start_tx for one cycle.
  - TX_WAIT_BUSY waits for tx_idle == 0.
  - TX_WAIT_DONE waits for tx_idle == 1.
  - Advance to the next byte; after byte 5 go to RX_HDR0.
  - tx_data holds its value from the strobe until the next load.
- FSM states and transitions:
  - IDLE: req → clear err_code, busy = 1, byte index = 0, go to TX_LOAD.
  - TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE: transmit the five query bytes as above. No timeout applies during TX.
  - RX_HDR0: rx_ok with 0xAA → RX_HDR1; any other byte is ignored.
  - RX_HDR1: 0x55 → RX_CTRL; 0xAA → stay in RX_HDR1; any other byte → RX_HDR0.
  - RX_CTRL: byte ≠ CTRL_ENQUIRE → ERR(1); otherwise accumulate it into the checksum → RX_LEN.
  - RX_LEN: byte ≠ PAYLOAD_LEN → ERR(1); otherwise accumulate → RX_PAY.
  - RX_PAY: shift each byte into a 128-bit shadow register and accumulate; after 16 bytes → RX_CHK.
  - RX_CHK: match → copy the shadow into all six outputs in the same cycle, para_valid = 1, done pulse → IDLE. Mismatch → ERR(2).
  - ERR: err pulse and err_code set for one cycle, then → IDLE. Output parameters are left untouched.
- Timeout:
  - The counter clears on entry to RX_HDR0 and increments every cycle in the RX_* states.
  - Reaching TIMEOUT_CYCLES−1 without completing RX_CHK → ERR(3).
  - If a timeout and an rx_ok occur in the same cycle, the timeout wins.
- busy is 1 from the cycle after req until the cycle in which done/err pulses; it is 0 in the pulse cycle.
- req while busy is ignored.
- rx_ok outside the RX_* states is ignored.
- Reset mid-transaction aborts immediately; start_tx must not assert in the cycle following reset release.
- Checksum accumulator is 8-bit wrap-around and clears on entry to RX_HDR0 and on every header resync.

Decomposition:
- Shared package mcu_link_pkg holds:
  - frame constants HDR0 = 8'hAA and HDR1 = 8'h55;
  - the ctrl-code constants;
  - err_code localparams;
  - the FSM state encoding.
- One natural sub-module, frame_chk_accum: an 8-bit running checksum with clr and add inputs. The same sub-module is reusable by the responder-side blocks.

Test Plan:
- Nominal transaction:
  - Stimulus: req; the UART model echoes the tx_idle handshake. The bench checks the tx byte sequence is AA 55 21 00 21. Then reply AA 55 21 10 00 98 96 80 00 0A 01 F4 00 00 0F A0 00 05 00 C8 CHK.
  - Required response: done pulse; tw_freq = 0x00989680; tw_dur = 10; tw_thr = 500; pf_freq = 4000; pf_dur = 5; pf_thr = 200; para_valid = 1; busy = 0.
- Bad checksum:
  - Stimulus: the same reply with CHK+1.
  - Required response: err pulse, err_code = 2, all parameters unchanged from the previous values.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES set to 1000, no reply.
  - Required response: err exactly 1000 cycles after RX_HDR0 entry, err_code = 3.
- Header resync:
  - Stimulus: garbage 12 AA 34 AA AA 55 followed by a valid reply.
  - Required response: done, with correct parameters.
- Ctrl mismatch:
  - Stimulus: reply ctrl byte 0x22.
  - Required response: err_code = 1 immediately after that byte; the remaining bytes are ignored in IDLE.
- Reset and request-while-busy:
  - Stimulus 1: rst = 0 after the 8th payload byte. Required response: all outputs 0 next cycle. A subsequent req works normally.
  - Stimulus 2: req asserted while busy. Required response: no effect, no extra start_tx.

Source files
------------

// File: rtl/mcu_link_pkg.sv
// rtl/mcu_link_pkg.sv - shared FPGA<->MCU link constants, error codes and master FSM encoding
package mcu_link_pkg;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

    localparam logic [7:0] CTRL_ENQUIRE_CODE = 8'h21;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HDR     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_LOAD,
        ST_TX_WAIT_BUSY,
        ST_TX_WAIT_DONE,
        ST_RX_HDR0,
        ST_RX_HDR1,
        ST_RX_CTRL,
        ST_RX_LEN,
        ST_RX_PAY,
        ST_RX_CHK,
        ST_ERR
    } master_state_e;

endpackage

// File: rtl/frame_chk_accum.sv
// rtl/frame_chk_accum.sv - 8-bit wrap-around running frame checksum
// Ports: clk, rst (sync, active-low), clr (zero the sum, wins over add),
//        add (accumulate din), din[7:0], sum[7:0] (current running sum).
module frame_chk_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (add) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/mcu_para_enquire_master.sv
// rtl/mcu_para_enquire_master.sv - parameter-enquire initiator: sends query, validates reply, latches parameters
// Ports: clk, rst (sync, active-low); req (enquire pulse);
//        tx_idle / tx_data / start_tx (byte UART transmitter handshake);
//        rx_data / rx_ok (received byte stream);
//        busy, done, err, err_code (transaction status);
//        six acquisition parameter outputs and para_valid.
module mcu_para_enquire_master
    import mcu_link_pkg::*;
#(
    parameter logic [7:0]  CTRL_ENQUIRE   = CTRL_ENQUIRE_CODE,
    parameter logic [7:0]  PAYLOAD_LEN    = 8'd16,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned TO_W           = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        tx_idle,
    output logic [7:0]  tx_data,
    output logic        start_tx,
    input  logic [7:0]  rx_data,
    input  logic        rx_ok,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] travelling_wave_collect_freq,
    output logic [15:0] travelling_wave_collect_duration,
    output logic [15:0] travelling_wave_alarm_threshold,
    output logic [31:0] power_frequency_collect_freq,
    output logic [15:0] power_frequency_collect_duration,
    output logic [15:0] power_frequency_alarm_threshold,
    output logic        para_valid
);

    master_state_e   state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      pay_cnt_q, pay_cnt_d;
    logic [127:0]    shadow_q, shadow_d;
    logic [127:0]    param_q, param_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            start_tx_q, start_tx_d;
    logic            done_q, done_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            para_valid_q, para_valid_d;

    logic            chk_clr, chk_add;
    logic [7:0]      chk_sum;
    logic            rx_state, timeout;
    logic [7:0]      query_byte;

    frame_chk_accum u_chk (
        .clk (clk),
        .rst (rst),
        .clr (chk_clr),
        .add (chk_add),
        .din (rx_data),
        .sum (chk_sum)
    );

    // Query frame: AA 55 CTRL 00 CHK, CHK covering CTRL and LEN only.
    always_comb begin
        case (idx_q)
            3'd0:    query_byte = HDR0;
            3'd1:    query_byte = HDR1;
            3'd2:    query_byte = CTRL_ENQUIRE;
            3'd3:    query_byte = 8'h00;
            default: query_byte = CTRL_ENQUIRE + 8'h00;
        endcase
    end

    assign rx_state = (state_q inside {ST_RX_HDR0, ST_RX_HDR1, ST_RX_CTRL,
                                       ST_RX_LEN, ST_RX_PAY, ST_RX_CHK});
    assign timeout  = rx_state && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pay_cnt_d    = pay_cnt_q;
        shadow_d     = shadow_q;
        param_d      = param_q;
        to_cnt_d     = rx_state ? to_cnt_q + 1'b1 : to_cnt_q;
        tx_data_d    = tx_data_q;
        start_tx_d   = 1'b0;
        done_d       = 1'b0;
        err_code_d   = err_code_q;
        para_valid_d = para_valid_q;
        chk_clr      = 1'b0;
        chk_add      = 1'b0;

        // A timeout pre-empts whatever byte arrives in the same cycle.
        if (timeout) begin
            state_d    = ST_ERR;
            err_code_d = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        err_code_d = ERR_NONE;
                        idx_d      = 3'd0;
                        state_d    = ST_TX_LOAD;
                    end
                end
                ST_TX_LOAD: begin
                    if (tx_idle) begin
                        tx_data_d  = query_byte;
                        start_tx_d = 1'b1;
                        state_d    = ST_TX_WAIT_BUSY;
                    end
                end
                ST_TX_WAIT_BUSY: begin
                    if (!tx_idle) state_d = ST_TX_WAIT_DONE;
                end
                ST_TX_WAIT_DONE: begin
                    if (tx_idle) begin
                        if (idx_q == 3'd4) begin
                            state_d  = ST_RX_HDR0;
                            to_cnt_d = '0;
                            chk_clr  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = ST_TX_LOAD;
                        end
                    end
                end
                ST_RX_HDR0: begin
                    chk_clr = 1'b1;
                    if (rx_ok && rx_data == HDR0) state_d = ST_RX_HDR1;
                end
                ST_RX_HDR1: begin
                    // Repeated AA keeps us aligned on a possible header start.
                    chk_clr = 1'b1;
                    if (rx_ok) begin
                        if (rx_data == HDR1)      state_d = ST_RX_CTRL;
                        else if (rx_data != HDR0) state_d = ST_RX_HDR0;
                    end
                end
                ST_RX_CTRL: begin
                    if (rx_ok) begin
                        if (rx_data != CTRL_ENQUIRE) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_HDR;
                        end else begin
                            chk_add = 1'b1;
                            state_d = ST_RX_LEN;
                        end
                    end
                end
                ST_RX_LEN: begin
                    if (rx_ok) begin
                        if (rx_data != PAYLOAD_LEN) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_HDR;
                        end else begin
                            chk_add   = 1'b1;
                            pay_cnt_d = 4'd0;
                            state_d   = ST_RX_PAY;
                        end
                    end
                end
                ST_RX_PAY: begin
                    if (rx_ok) begin
                        shadow_d  = {shadow_q[119:0], rx_data};
                        chk_add   = 1'b1;
                        pay_cnt_d = pay_cnt_q + 4'd1;
                        if (pay_cnt_q == 4'd15) state_d = ST_RX_CHK;
                    end
                end
                ST_RX_CHK: begin
                    if (rx_ok) begin
                        if (rx_data == chk_sum) begin
                            param_d      = shadow_q;
                            para_valid_d = 1'b1;
                            done_d       = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_CHK;
                        end
                    end
                end
                ST_ERR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pay_cnt_q    <= '0;
            shadow_q     <= '0;
            param_q      <= '0;
            to_cnt_q     <= '0;
            tx_data_q    <= '0;
            start_tx_q   <= 1'b0;
            done_q       <= 1'b0;
            err_code_q   <= ERR_NONE;
            para_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pay_cnt_q    <= pay_cnt_d;
            shadow_q     <= shadow_d;
            param_q      <= param_d;
            to_cnt_q     <= to_cnt_d;
            tx_data_q    <= tx_data_d;
            start_tx_q   <= start_tx_d;
            done_q       <= done_d;
            err_code_q   <= err_code_d;
            para_valid_q <= para_valid_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign start_tx   = start_tx_q;
    assign done       = done_q;
    assign err        = (state_q == ST_ERR);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign err_code   = err_code_q;
    assign para_valid = para_valid_q;

    // Payload arrives big-endian, first byte ends up in the top of the shadow.
    assign travelling_wave_collect_freq     = param_q[127:96];
    assign travelling_wave_collect_duration = param_q[95:80];
    assign travelling_wave_alarm_threshold  = param_q[79:64];
    assign power_frequency_collect_freq     = param_q[63:32];
    assign power_frequency_collect_duration = param_q[31:16];
    assign power_frequency_alarm_threshold  = param_q[15:0];

endmodule
